// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared types and size constants for the Hack data memory family
package hack_mem_pkg;

    localparam int WORD_W     = 16;
    localparam int ADDR_W_4K  = 12;
    localparam int ADDR_W_8K  = 13;
    localparam int ADDR_W_16K = 14;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - clear sequencer: walks every address once after reset or on request
module ram_clear_seq
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_16K
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The reset edge itself never writes; the first clear write is on the following edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = !reset;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_sync_clr.sv
// rtl/ram_sync_clr.sv - registered-read RAM with write-first bypass and built-in clear
module ram_sync_clr
    import hack_mem_pkg::*;
#(
    parameter int               WIDTH    = WORD_W,
    parameter int               ADDR_W   = ADDR_W_16K,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              clr,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy,
    output logic              load_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              bypass;
    logic [WIDTH-1:0]  mem [DEPTH];

    ram_clear_seq #(
        .ADDR_W(ADDR_W)
    ) u_seq (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // A clear request in the same cycle wins over a user write.
    assign user_we = load && !clr && !busy && !reset;
    assign bypass  = user_we && (raddr == waddr);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (user_we) begin
            mem[waddr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            load_drop <= 1'b0;
        end else if (busy) begin
            out_valid <= 1'b0;
            load_drop <= load;
        end else begin
            out_valid <= rd_en;
            load_drop <= load && clr;
            if (rd_en) out <= bypass ? in : mem[raddr];
        end
    end

endmodule

// File: tb/tb_ram_sync_clr.sv
// tb/tb_ram_sync_clr.sv - scoreboard bench for ram_sync_clr (small and default sizes)
module tb_ram_sync_clr;

    localparam logic [15:0] IV = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1, load = 1'b0, rd_en = 1'b0, clr = 1'b0;
    logic [15:0] in = '0;
    logic [2:0]  waddr = '0, raddr = '0;
    logic [15:0] out;
    logic        out_valid, busy, load_drop;

    logic        b_reset = 1'b1, b_load = 1'b0, b_rd_en = 1'b0, b_clr = 1'b0;
    logic [15:0] b_in = '0;
    logic [13:0] b_waddr = '0, b_raddr = '0;
    logic [15:0] b_out;
    logic        b_out_valid, b_busy, b_load_drop;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_v;
    int          n;

    always #5 clk = ~clk;

    ram_sync_clr #(.WIDTH(16), .ADDR_W(3), .INIT_VAL(IV)) dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .waddr(waddr),
        .rd_en(rd_en), .raddr(raddr), .clr(clr), .out(out),
        .out_valid(out_valid), .busy(busy), .load_drop(load_drop)
    );

    ram_sync_clr dut_big (
        .clk(clk), .reset(b_reset), .in(b_in), .load(b_load), .waddr(b_waddr),
        .rd_en(b_rd_en), .raddr(b_raddr), .clr(b_clr), .out(b_out),
        .out_valid(b_out_valid), .busy(b_busy), .load_drop(b_load_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out); end
        checks++; if (load_drop !== 1'b0) begin errors++; $display("FAIL reset_load_drop: got %b expected 0", load_drop); end
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL reset_busy_len: got %0d expected 8", n); end
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; raddr = 3'(a); sb.push_back(IV);
            step();
            exp_v = sb.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL init_valid[%0d]: got %b expected 1", a, out_valid); end
            checks++; if (out !== exp_v) begin errors++; $display("FAIL init_data[%0d]: got %h expected %h", a, out, exp_v); end
        end
        rd_en = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_write_read();
        load = 1'b1; waddr = 3'd3; in = 16'h1234;
        step();
        load = 1'b0;
        rd_en = 1'b1; raddr = 3'd3; sb.push_back(16'h1234);
        step();
        exp_v = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out !== exp_v) begin errors++; $display("FAIL wr_rd3: got %b/%h expected 1/%h", out_valid, out, exp_v); end
        raddr = 3'd4; sb.push_back(IV);
        step();
        exp_v = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out !== exp_v) begin errors++; $display("FAIL wr_rd4: got %b/%h expected 1/%h", out_valid, out, exp_v); end
        rd_en = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out !== IV) begin errors++; $display("FAIL hold_out: got %b/%h expected 0/%h", out_valid, out, IV); end
    endtask

    task automatic test_bypass();
        load = 1'b1; waddr = 3'd5; in = 16'hBEEF;
        rd_en = 1'b1; raddr = 3'd5; sb.push_back(16'hBEEF);
        step();
        exp_v = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out !== exp_v) begin errors++; $display("FAIL bypass: got %b/%h expected 1/%h", out_valid, out, exp_v); end
        load = 1'b0; in = 16'h0000; sb.push_back(16'hBEEF);
        step();
        exp_v = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out !== exp_v) begin errors++; $display("FAIL bypass_stored: got %b/%h expected 1/%h", out_valid, out, exp_v); end
        rd_en = 1'b0;
    endtask

    task automatic test_clr_drop();
        load = 1'b1; waddr = 3'd2; in = 16'h7777; clr = 1'b1;
        rd_en = 1'b1; raddr = 3'd5; sb.push_back(16'hBEEF);
        step();
        exp_v = sb.pop_front();
        checks++; if (load_drop !== 1'b1) begin errors++; $display("FAIL clr_load_drop: got %b expected 1", load_drop); end
        checks++; if (out_valid !== 1'b1 || out !== exp_v) begin errors++; $display("FAIL clr_preread: got %b/%h expected 1/%h", out_valid, out, exp_v); end
        load = 1'b0; clr = 1'b0; rd_en = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL clr_busy_len: got %0d expected 8", n); end
        checks++; if (load_drop !== 1'b0) begin errors++; $display("FAIL clr_drop_pulse: got %b expected 0", load_drop); end
        for (int a = 2; a <= 5; a += 3) begin
            rd_en = 1'b1; raddr = 3'(a); sb.push_back(IV);
            step();
            exp_v = sb.pop_front();
            checks++; if (out_valid !== 1'b1 || out !== exp_v) begin errors++; $display("FAIL after_clr[%0d]: got %b/%h expected 1/%h", a, out_valid, out, exp_v); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_clear_traffic();
        clr = 1'b1;
        step();
        clr = 1'b0;
        load = 1'b1; waddr = 3'd1; in = 16'h1111; rd_en = 1'b1; raddr = 3'd1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL busy_rd_valid: got %b expected 0", out_valid); end
        checks++; if (out !== IV) begin errors++; $display("FAIL busy_rd_hold: got %h expected %h", out, IV); end
        checks++; if (load_drop !== 1'b1) begin errors++; $display("FAIL busy_load_drop: got %b expected 1", load_drop); end
        load = 1'b0; rd_en = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b1 || out !== 16'h0000) begin errors++; $display("FAIL midclr_reset: got %b/%h expected 1/0000", busy, out); end
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 8) begin errors++; $display("FAIL midclr_busy_len: got %0d expected 8", n); end
        rd_en = 1'b1; raddr = 3'd1; sb.push_back(IV);
        step();
        exp_v = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || out !== exp_v) begin errors++; $display("FAIL busy_write_lost: got %b/%h expected 1/%h", out_valid, out, exp_v); end
        rd_en = 1'b0;
    endtask

    task automatic test_default_depth();
        b_reset = 1'b1;
        step();
        b_reset = 1'b0;
        n = 0;
        while (b_busy === 1'b1 && n < 20000) begin step(); n++; end
        checks++; if (n != 16384) begin errors++; $display("FAIL big_busy_len: got %0d expected 16384", n); end
        b_load = 1'b1; b_waddr = 14'd16383; b_in = 16'hC0DE;
        step();
        b_load = 1'b0;
        b_rd_en = 1'b1; b_raddr = 14'd16383; sb.push_back(16'hC0DE);
        step();
        exp_v = sb.pop_front();
        checks++; if (b_out_valid !== 1'b1 || b_out !== exp_v) begin errors++; $display("FAIL big_top: got %b/%h expected 1/%h", b_out_valid, b_out, exp_v); end
        b_raddr = 14'd0; sb.push_back(16'h0000);
        step();
        exp_v = sb.pop_front();
        checks++; if (b_out_valid !== 1'b1 || b_out !== exp_v) begin errors++; $display("FAIL big_alias0: got %b/%h expected 1/%h", b_out_valid, b_out, exp_v); end
        b_rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_clr_drop();
        test_clear_traffic();
        test_default_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
